// File: rtl/regfile_scoreboard.sv
// Register file with NREAD combinational read ports, one writeback port and a per-register
// pending-writer scoreboard. Define REGFILE_BYPASS_EN to forward writeback data and retire status to decode.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int CNTW  = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREAD*AW-1:0]    rd_addr,
    input  logic [NREAD-1:0]       rd_use,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    output logic                   hazard,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_rd,
    input  logic [XLEN-1:0]        wb_data
);

    localparam logic [CNTW-1:0] CMAX = '1;

    // x0 is hardwired: neither data nor counter storage exists for it
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic [CNTW-1:0] cnt_q  [1:NREGS-1];
    logic [CNTW-1:0] cnt_d  [1:NREGS-1];

    logic            wr_en;
    logic            retire;
    logic            issue_fire;
    logic [CNTW-1:0] issue_cnt;
    logic [CNTW-1:0] wb_cnt;

    assign wr_en       = wb_valid & wb_we & (wb_rd != '0);
    assign retire      = wb_valid & (wb_rd != '0);
    assign issue_cnt   = (issue_rd == '0) ? '0 : cnt_q[issue_rd];
    assign wb_cnt      = (wb_rd == '0) ? '0 : cnt_q[wb_rd];
    assign issue_ready = (issue_rd == '0) | (issue_cnt != CMAX);
    assign hazard      = issue_valid & ((|(rd_use & rd_busy)) | ~issue_ready);
    assign issue_fire  = issue_valid & ~hazard & (issue_rd != '0);

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdat;
        logic [CNTW-1:0] rcnt;

        assign addr = rd_addr[i*AW +: AW];
        assign rdat = (addr == '0) ? '0 : regs_q[addr];
        assign rcnt = (addr == '0) ? '0 : cnt_q[addr];

`ifdef REGFILE_BYPASS_EN
        // Busy looks at the post-retire count so the consumer can leave decode in the writeback cycle
        assign rd_data[i*XLEN +: XLEN] = (wr_en && wb_rd == addr) ? wb_data : rdat;
        assign rd_busy[i] = (rcnt != '0) & ~(retire && wb_rd == addr && rcnt == CNTW'(1));
`else
        assign rd_data[i*XLEN +: XLEN] = rdat;
        assign rd_busy[i] = (rcnt != '0);
`endif
    end

    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            if (wr_en && wb_rd == AW'(r))
                regs_d[r] = wb_data;
            // Issue and retire on the same register cancel; a retire at zero saturates
            if (issue_fire && issue_rd == AW'(r) && !(retire && wb_rd == AW'(r)))
                cnt_d[r] = cnt_q[r] + CNTW'(1);
            else if (retire && wb_rd == AW'(r) && !(issue_fire && issue_rd == AW'(r))
                     && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(retire && wb_cnt == '0))
        else $error("regfile_scoreboard: retire on x%0d with no pending writer", wb_rd);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, writes, hazards, counter saturation,
// simultaneous issue/retire, killed retire and asynchronous reset.
module tb_regfile_scoreboard;

    localparam int XLEN = 32, NREGS = 32, NREAD = 2, CNTW = 2, AW = 5;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD-1:0]      rd_use;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  hazard;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_ready;
    logic                  wb_valid;
    logic                  wb_we;
    logic [AW-1:0]         wb_rd;
    logic [XLEN-1:0]       wb_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data), .rd_busy(rd_busy),
        .hazard(hazard),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_set(input logic v, input logic we, input logic [AW-1:0] rd,
                          input logic [XLEN-1:0] d);
        wb_valid = v; wb_we = we; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        reset = 1'b0;
        rd_addr = '0; rd_use = '0;
        issue_valid = 1'b0; issue_rd = '0;
        wb_set(1'b0, 1'b0, '0, '0);
        #2;

        // Reset values for every address on both ports, with an issue request pending
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            #0.1;
            check("rst_data0", rd_data[31:0], 32'h0);
            check("rst_data1", rd_data[63:32], 32'h0);
            check("rst_busy", {30'b0, rd_busy}, 32'h0);
        end
        issue_valid = 1'b1; issue_rd = 5'd5; rd_use = 2'b11;
        #1;
        check("rst_ready", {31'b0, issue_ready}, 32'h1);
        check("rst_hazard", {31'b0, hazard}, 32'h0);
        issue_valid = 1'b0; rd_use = '0;
        #1;
        reset = 1'b1;

        // Issue x5 then write 0xDEADBEEF back; visible on port 1 next cycle
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        rd_addr = {5'd5, 5'd5};
        #1;
        check("x5_busy", {30'b0, rd_busy}, 32'h3);
        wb_set(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        wb_set(1'b0, 1'b0, '0, '0);
        #1;
        check("x5_data", rd_data[63:32], 32'hDEADBEEF);
        check("x5_idle", {31'b0, rd_busy[1]}, 32'h0);

        // Writes to x0 are discarded
        wb_set(1'b1, 1'b1, 5'd0, 32'h1234);
        tick();
        wb_set(1'b0, 1'b0, '0, '0);
        rd_addr = '0;
        #1;
        check("x0_data", rd_data[31:0], 32'h0);
        check("x0_busy", {30'b0, rd_busy}, 32'h0);

        // RAW hazard on x7
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_rd = 5'd8; rd_addr = {5'd0, 5'd7}; rd_use = 2'b01;
        #1;
        check("x7_hazard", {31'b0, hazard}, 32'h1);
        rd_use = 2'b00;
        #1;
        check("x7_unused", {31'b0, hazard}, 32'h0);
        rd_use = 2'b01;
        wb_set(1'b1, 1'b1, 5'd7, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x7_wb_hazard", {31'b0, hazard}, 32'h0);
        check("x7_wb_data", rd_data[31:0], 32'h55);
`else
        check("x7_wb_hazard", {31'b0, hazard}, 32'h1);
        check("x7_wb_data", rd_data[31:0], 32'h0);
`endif
        issue_valid = 1'b0;
        tick();
        wb_set(1'b0, 1'b0, '0, '0);
        issue_valid = 1'b1;
        #1;
        check("x7_after_hazard", {31'b0, hazard}, 32'h0);
        check("x7_after_data", rd_data[31:0], 32'h55);
        check("x7_after_busy", {31'b0, rd_busy[0]}, 32'h0);
        issue_valid = 1'b0; rd_use = '0;

        // Saturate the x3 counter
        issue_valid = 1'b1; issue_rd = 5'd3; rd_addr = {5'd0, 5'd3};
        for (int k = 0; k < 3; k++) tick();
        check("x3_full_ready", {31'b0, issue_ready}, 32'h0);
        check("x3_full_hazard", {31'b0, hazard}, 32'h1);
        tick();
        check("x3_still_full", {31'b0, issue_ready}, 32'h0);
        issue_valid = 1'b0;
        wb_set(1'b1, 1'b1, 5'd3, 32'h33);
        tick();
        check("x3_ready_back", {31'b0, issue_ready}, 32'h1);
        check("x3_busy_2", {31'b0, rd_busy[0]}, 32'h1);
        tick();
        check("x3_busy_1", {31'b0, rd_busy[0]}, 32'h1);
        tick();
        wb_set(1'b0, 1'b0, '0, '0);
        #1;
        check("x3_busy_0", {31'b0, rd_busy[0]}, 32'h0);
        check("x3_data", rd_data[31:0], 32'h33);

        // Simultaneous issue and retire on x9, then a killed retire
        issue_valid = 1'b1; issue_rd = 5'd9; rd_addr = {5'd0, 5'd9};
        tick();
        wb_set(1'b1, 1'b1, 5'd9, 32'h99);
        tick();
        issue_valid = 1'b0;
        wb_set(1'b0, 1'b0, '0, '0);
        #1;
        check("x9_same_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("x9_same_data", rd_data[31:0], 32'h99);
        wb_set(1'b1, 1'b0, 5'd9, 32'hBAD);
        tick();
        wb_set(1'b0, 1'b0, '0, '0);
        #1;
        check("x9_kill_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("x9_kill_data", rd_data[31:0], 32'h99);

        // Asynchronous reset with cnt[4] = 2 and x4 = 0xA5
        issue_valid = 1'b1; issue_rd = 5'd4;
        for (int k = 0; k < 3; k++) tick();
        issue_valid = 1'b0;
        wb_set(1'b1, 1'b1, 5'd4, 32'hA5);
        tick();
        wb_set(1'b0, 1'b0, '0, '0);
        rd_addr = {5'd5, 5'd4}; rd_use = 2'b01; issue_valid = 1'b1;
        #1;
        check("x4_pre_data", rd_data[31:0], 32'hA5);
        check("x4_pre_hazard", {31'b0, hazard}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_data", rd_data[31:0], 32'h0);
        check("arst_x5", rd_data[63:32], 32'h0);
        check("arst_busy", {30'b0, rd_busy}, 32'h0);
        check("arst_hazard", {31'b0, hazard}, 32'h0);
        check("arst_ready", {31'b0, issue_ready}, 32'h1);
        #1;
        reset = 1'b1;
        issue_valid = 1'b0; rd_use = '0;
        tick();
        check("post_rst_data", rd_data[31:0], 32'h0);
        check("post_rst_busy", {31'b0, rd_busy[0]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
